// File: rtl/popcount_frame_accumulator_pkg.sv
// Shared types and helpers for the popcount framing stage.
// The clamp bound equals the population-counter width (64 inputs).
package popcount_pkg;

    localparam int unsigned CNT_MAX = 64;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } acc_state_e;

    function automatic int unsigned clamp_cnt(input int unsigned cnt);
        return (cnt > CNT_MAX) ? CNT_MAX : cnt;
    endfunction

endpackage

// File: rtl/popcount_frame_accumulator_if.sv
// Word-in / result-out handshake bundle for the popcount frame accumulator.
// slave is the accumulator's view; master is the surrounding environment's view.
interface popcount_frame_accumulator_if #(
    parameter int unsigned CNT_W = 7,
    parameter int unsigned SUM_W = 11
);

    logic [CNT_W-1:0] cnt_i;
    logic             cnt_valid_i;
    logic             cnt_ready_o;
    logic [SUM_W-1:0] thresh_i;
    logic [SUM_W-1:0] sum_o;
    logic             over_o;
    logic             err_o;
    logic             res_valid_o;
    logic             res_ready_i;

    modport slave (
        input  cnt_i, cnt_valid_i, thresh_i, res_ready_i,
        output cnt_ready_o, sum_o, over_o, err_o, res_valid_o
    );

    modport master (
        output cnt_i, cnt_valid_i, thresh_i, res_ready_i,
        input  cnt_ready_o, sum_o, over_o, err_o, res_valid_o
    );

endinterface

// File: rtl/popcount_frame_accumulator_clamp.sv
// Saturates an incoming popcount word at CNT_MAX and flags words that
// could not have come from a 64-input counter.
module popcount_clamp
    import popcount_pkg::*;
#(
    parameter int unsigned CNT_W = 7
) (
    input  logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] cnt_clamped,
    output logic             illegal
);

    always_comb begin
        cnt_clamped = CNT_W'(clamp_cnt(32'(cnt)));
        illegal     = (32'(cnt) > CNT_MAX);
    end

endmodule

// File: rtl/popcount_frame_accumulator.sv
// Sums FRAME_WORDS popcount words per frame, compares the total against a
// threshold latched at word 1, and holds the result until it is taken.
module popcount_frame_accumulator
    import popcount_pkg::*;
#(
    parameter int unsigned FRAME_WORDS = 16,
    parameter int unsigned CNT_W       = 7,
    parameter int unsigned SUM_W       = 11
) (
    input  logic                         clk,
    input  logic                         rst,
    popcount_frame_accumulator_if.slave  bus
);

    localparam int unsigned     IDX_W    = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);

    acc_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    logic [SUM_W-1:0] acc_q;
    logic [SUM_W-1:0] thr_q;
    logic             err_acc_q;
    logic [SUM_W-1:0] sum_q;
    logic             over_q;
    logic             err_q;

    logic [CNT_W-1:0] cnt_clamped;
    logic             cnt_illegal;
    logic             accept;
    logic             frame_start;
    logic             frame_last;
    logic [SUM_W-1:0] acc_next;

    popcount_clamp #(
        .CNT_W (CNT_W)
    ) u_clamp (
        .cnt         (bus.cnt_i),
        .cnt_clamped (cnt_clamped),
        .illegal     (cnt_illegal)
    );

    // A word accepted while not in ACCUM (IDLE, or HOLD with the result
    // leaving in the same cycle) always opens a new frame.
    always_comb begin
        accept      = bus.cnt_valid_i & bus.cnt_ready_o;
        frame_start = accept & (state_q != ACCUM);
        frame_last  = accept & (state_q == ACCUM) & (idx_q == LAST_IDX);
        acc_next    = acc_q + SUM_W'(cnt_clamped);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ACCUM;
            ACCUM:   if (frame_last) state_d = HOLD;
            HOLD:    if (bus.res_ready_i) state_d = accept ? ACCUM : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.cnt_ready_o = (state_q != HOLD) | bus.res_ready_i;
        bus.res_valid_o = (state_q == HOLD);
        bus.sum_o       = sum_q;
        bus.over_o      = over_q;
        bus.err_o       = err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q     <= '0;
            acc_q     <= '0;
            thr_q     <= '0;
            err_acc_q <= 1'b0;
            sum_q     <= '0;
            over_q    <= 1'b0;
            err_q     <= 1'b0;
        end else if (frame_start) begin
            idx_q     <= IDX_W'(1);
            acc_q     <= SUM_W'(cnt_clamped);
            thr_q     <= bus.thresh_i;
            err_acc_q <= cnt_illegal;
        end else if (frame_last) begin
            idx_q     <= '0;
            acc_q     <= acc_next;
            err_acc_q <= err_acc_q | cnt_illegal;
            sum_q     <= acc_next;
            over_q    <= (acc_next >= thr_q);
            err_q     <= err_acc_q | cnt_illegal;
        end else if (accept) begin
            idx_q     <= idx_q + IDX_W'(1);
            acc_q     <= acc_next;
            err_acc_q <= err_acc_q | cnt_illegal;
        end
    end

endmodule

// File: tb/tb_popcount_frame_accumulator.sv
// Directed scoreboard bench for popcount_frame_accumulator: stimulus pushes
// expected frame results, a negedge monitor compares every presented result.
module tb_popcount_frame_accumulator;

    localparam int unsigned FW = 16;
    localparam int unsigned CW = 7;
    localparam int unsigned SW = 11;

    typedef struct packed {
        logic [SW-1:0] sum;
        logic          over;
        logic          err;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    popcount_frame_accumulator_if #(.CNT_W(CW), .SUM_W(SW)) bus ();

    popcount_frame_accumulator #(
        .FRAME_WORDS (FW),
        .CNT_W       (CW),
        .SUM_W       (SW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    res_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic res_t model(input int unsigned vals[$], input int unsigned thr);
        res_t        r;
        int unsigned s = 0;
        logic        e = 1'b0;
        foreach (vals[i]) begin
            s += (vals[i] > 64) ? 64 : vals[i];
            e |= (vals[i] > 64);
        end
        r.sum  = SW'(s);
        r.over = (s >= thr);
        r.err  = e;
        return r;
    endfunction

    // Result checker: while a result is presented it must equal the head of the
    // scoreboard every cycle; it is retired on transfer.
    always @(negedge clk) begin
        if (!rst && bus.res_valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result actual sum=%0d expected none", bus.sum_o);
            end else begin
                check("res_sum", bus.sum_o, exp_q[0].sum);
                check("res_over", bus.over_o, exp_q[0].over);
                check("res_err", bus.err_o, exp_q[0].err);
                if (bus.res_ready_i) void'(exp_q.pop_front());
            end
        end
    end

    task automatic send_word(input int unsigned w);
        int unsigned n = 0;
        bus.cnt_i       = CW'(w);
        bus.cnt_valid_i = 1'b1;
        @(negedge clk);
        while (!bus.cnt_ready_o && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL word_accept_timeout actual=stalled expected=accepted");
        end
        @(posedge clk);
        #1;
        bus.cnt_valid_i = 1'b0;
    endtask

    task automatic send_frame(input int unsigned vals[$], input int unsigned thr, input bit gaps);
        exp_q.push_back(model(vals, thr));
        bus.thresh_i = SW'(thr);
        foreach (vals[i]) begin
            send_word(vals[i]);
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    initial begin
        int unsigned v[$];
        int unsigned vb[$];
        int unsigned n;

        rst             = 1'b1;
        bus.cnt_i       = '0;
        bus.cnt_valid_i = 1'b0;
        bus.thresh_i    = '0;
        bus.res_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("reset_cnt_ready", bus.cnt_ready_o, 1);
        check("reset_res_valid", bus.res_valid_o, 0);
        check("reset_sum", bus.sum_o, 0);
        check("reset_over", bus.over_o, 0);
        check("reset_err", bus.err_o, 0);
        @(posedge clk);
        #1;

        // Basic frame, result visible the cycle after word 16.
        v = {};
        repeat (FW) v.push_back(4);
        send_frame(v, 64, 1'b0);
        @(negedge clk);
        check("latency_valid", bus.res_valid_o, 1);
        @(posedge clk);
        #1;

        // Back-pressure: result held 5 cycles, next frame's word 1 rides the transfer.
        bus.res_ready_i = 1'b0;
        v = {};
        repeat (FW) v.push_back(2);
        send_frame(v, 32, 1'b0);
        vb = {};
        repeat (FW) vb.push_back(3);
        fork
            send_frame(vb, 0, 1'b0);
            begin
                repeat (5) begin
                    @(negedge clk);
                    check("bp_cnt_ready_low", bus.cnt_ready_o, 0);
                    check("bp_res_valid_high", bus.res_valid_o, 1);
                end
                @(posedge clk);
                #1 bus.res_ready_i = 1'b1;
                @(negedge clk);
                check("bp_concurrent_transfer",
                      {bus.res_valid_o, bus.cnt_valid_i, bus.cnt_ready_o}, 3'b111);
            end
        join

        // Saturation/error frame followed back-to-back by an all-zero frame.
        v = {100};
        repeat (FW - 1) v.push_back(64);
        send_frame(v, 1000, 1'b0);
        v = {};
        repeat (FW) v.push_back(0);
        send_frame(v, 1, 1'b0);

        // Gaps: 1..16 with random idle cycles, threshold just above the total.
        v = {};
        for (int unsigned i = 1; i <= FW; i++) v.push_back(i);
        send_frame(v, 137, 1'b1);

        // Threshold changes after word 1; the word-1 value must govern.
        v = {};
        repeat (FW) v.push_back(64);
        exp_q.push_back(model(v, 10));
        bus.thresh_i = SW'(10);
        send_word(64);
        bus.thresh_i = SW'(2000);
        repeat (FW - 1) send_word(64);

        // Reset after word 7 discards the partial frame.
        repeat (3) @(negedge clk);
        bus.thresh_i = SW'(0);
        repeat (7) send_word(5);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_res_valid", bus.res_valid_o, 0);
        check("rst_mid_cnt_ready", bus.cnt_ready_o, 1);
        @(posedge clk);
        #1;
        v = {};
        repeat (FW) v.push_back(1);
        send_frame(v, 16, 1'b0);

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("scoreboard_drained", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        check("final_res_valid", bus.res_valid_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
